snd_play_ctrl: RTL and testbench

SND_PLAY_CTRL -- requirements
Module: snd_play_ctrl

---
 rtl/snd_pkg.sv | 28 ++
 rtl/snd_rate_tick.sv | 33 +++
 rtl/snd_play_ctrl.sv | 163 ++++++++++++++++
 tb/tb_snd_play_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/snd_pkg.sv
// Shared encodings for the sound playback controller: FSM states, command codes,
// sample-rate divider width and underrun counter helpers.
package snd_pkg;

    localparam int RATE_W = 12;
    localparam int UCNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CMD_STOP  = 2'b00,
        CMD_PLAY  = 2'b01,
        CMD_PAUSE = 2'b10,
        CMD_FLUSH = 2'b11
    } cmd_t;

    // Saturating increment for the underrun statistics counter.
    function automatic logic [UCNT_W-1:0] sat_inc(input logic [UCNT_W-1:0] v);
        return (v == {UCNT_W{1'b1}}) ? v : v + UCNT_W'(1);
    endfunction

endpackage

// File: rtl/snd_rate_tick.sv
// Sample-rate divider: counts 0..rate_div while enabled and flags the terminal
// count; held at zero whenever disabled so each enable starts a fresh period.
module snd_rate_tick
    import snd_pkg::*;
(
    input  logic              ACLK,
    input  logic              ARST,
    input  logic              enable,
    input  logic [RATE_W-1:0] rate_div,
    output logic              tick
);

    logic [RATE_W-1:0] cnt_q;
    logic [RATE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (enable && (cnt_q != rate_div)) begin
            cnt_d = cnt_q + RATE_W'(1);
        end
    end

    assign tick = enable && (cnt_q == rate_div);

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/snd_play_ctrl.sv
// Playback sequencer between the sample buffer and the PWM stage.
// Optional SND_UNDERRUN_CNT_EN adds the saturating UNDER_CNT statistics port.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | stopped, waiting for a play command
// PRIME    | waiting for buffer occupancy to reach PRIME_LEVEL
// PLAY     | divider running, one sample fetched per tick
// PAUSE    | halted, resumes straight to PLAY without re-priming
// FLUSH    | two-cycle buffer clear, then IDLE
module snd_play_ctrl
    import snd_pkg::*;
#(
    parameter int PRIME_LEVEL = 256,
    parameter int CNT_W       = 11
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic [1:0]        COMMAND,
    input  logic [RATE_W-1:0] RATE_DIV,
    input  logic [CNT_W-1:0]  BUF_COUNT,
    input  logic              BUF_EMPTY,
    input  logic              DST_READY,
    output logic              BUF_RD,
    output logic              BUF_FLUSH,
    output logic              PLAYING,
    output logic              UNDERRUN
`ifdef SND_UNDERRUN_CNT_EN
    ,
    output logic [UCNT_W-1:0] UNDER_CNT
`endif
);

    state_t state_q, state_d;
    cmd_t   cmd_q, cmd_d;
    logic   pending_q, pending_d;
    logic   rd_q, rd_d;
    logic   under_q, under_d;
    logic   fl_cnt_q, fl_cnt_d;

    logic   tick;
    logic   primed;
    logic   play_stay;
    logic   empty_tick;
    logic   consume;
    logic   late_tick;

    snd_rate_tick u_rate_tick (
        .ACLK     (ACLK),
        .ARST     (ARST),
        .enable   (state_q == ST_PLAY),
        .rate_div (RATE_DIV),
        .tick     (tick)
    );

    assign cmd_d  = cmd_t'(COMMAND);
    assign primed = (BUF_COUNT >= CNT_W'(PRIME_LEVEL));

    // Sample handling only happens while PLAY is held for the next cycle too,
    // so a read strobe can never land outside PLAY or alongside BUF_FLUSH.
    assign play_stay  = (state_q == ST_PLAY) && (cmd_q == CMD_PLAY);
    assign empty_tick = play_stay && tick && BUF_EMPTY;
    assign consume    = play_stay && !empty_tick && pending_q && DST_READY && !BUF_EMPTY;
    assign late_tick  = play_stay && tick && !BUF_EMPTY && pending_q && !consume;

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if ((cmd_q == CMD_FLUSH) && (state_q != ST_FLUSH)) begin
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_q == CMD_PLAY) state_d = ST_PRIME;
                end
                ST_PRIME: begin
                    if (cmd_q == CMD_STOP)               state_d = ST_IDLE;
                    else if (cmd_q == CMD_PAUSE)         state_d = ST_PAUSE;
                    else if ((cmd_q == CMD_PLAY) && primed) state_d = ST_PLAY;
                end
                ST_PLAY: begin
                    if (cmd_q == CMD_STOP)       state_d = ST_IDLE;
                    else if (cmd_q == CMD_PAUSE) state_d = ST_PAUSE;
                    else if (empty_tick)         state_d = ST_PRIME;
                end
                ST_PAUSE: begin
                    if (cmd_q == CMD_STOP)      state_d = ST_IDLE;
                    else if (cmd_q == CMD_PLAY) state_d = ST_PLAY;
                end
                ST_FLUSH: begin
                    if (fl_cnt_q) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        BUF_FLUSH = (state_q == ST_FLUSH);
        PLAYING   = (state_q == ST_PLAY);
        BUF_RD    = rd_q;
        UNDERRUN  = under_q;
    end

    // At most one sample is ever owed: a tick while one is still pending is
    // reported as a miss rather than queued.
    always_comb begin
        pending_d = 1'b0;
        if (play_stay && !empty_tick) begin
            pending_d = tick || (pending_q && !consume);
        end
        rd_d     = consume;
        under_d  = empty_tick || late_tick;
        fl_cnt_d = (state_q == ST_FLUSH) ? !fl_cnt_q : 1'b0;
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            cmd_q     <= CMD_STOP;
            pending_q <= 1'b0;
            rd_q      <= 1'b0;
            under_q   <= 1'b0;
            fl_cnt_q  <= 1'b0;
        end else begin
            cmd_q     <= cmd_d;
            pending_q <= pending_d;
            rd_q      <= rd_d;
            under_q   <= under_d;
            fl_cnt_q  <= fl_cnt_d;
        end
    end

`ifdef SND_UNDERRUN_CNT_EN
    logic [UCNT_W-1:0] under_cnt_q, under_cnt_d;

    always_comb begin
        under_cnt_d = under_cnt_q;
        if (state_q == ST_FLUSH) begin
            under_cnt_d = '0;
        end else if (under_d) begin
            under_cnt_d = sat_inc(under_cnt_q);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            under_cnt_q <= '0;
        end else begin
            under_cnt_q <= under_cnt_d;
        end
    end

    assign UNDER_CNT = under_cnt_q;
`endif

endmodule

// File: tb/tb_snd_play_ctrl.sv
// Directed bench for snd_play_ctrl: prime, pacing, backpressure, pause/resume,
// flush, empty-buffer underrun, reset aborts and RATE_DIV=0.
module tb_snd_play_ctrl;

    logic        ACLK;
    logic        ARST;
    logic [1:0]  COMMAND;
    logic [11:0] RATE_DIV;
    logic [10:0] BUF_COUNT;
    logic        BUF_EMPTY;
    logic        DST_READY;
    logic        BUF_RD;
    logic        BUF_FLUSH;
    logic        PLAYING;
    logic        UNDERRUN;
`ifdef SND_UNDERRUN_CNT_EN
    logic [15:0] UNDER_CNT;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int bad, rdn, undn, fln, rd_pos, und_pos, fl_pos;

    snd_play_ctrl #(.PRIME_LEVEL(256), .CNT_W(11)) dut (
        .ACLK      (ACLK),
        .ARST      (ARST),
        .COMMAND   (COMMAND),
        .RATE_DIV  (RATE_DIV),
        .BUF_COUNT (BUF_COUNT),
        .BUF_EMPTY (BUF_EMPTY),
        .DST_READY (DST_READY),
        .BUF_RD    (BUF_RD),
        .BUF_FLUSH (BUF_FLUSH),
        .PLAYING   (PLAYING),
        .UNDERRUN  (UNDERRUN)
`ifdef SND_UNDERRUN_CNT_EN
        ,
        .UNDER_CNT (UNDER_CNT)
`endif
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ARST = 1'b1; COMMAND = 2'b00; RATE_DIV = 12'd3;
        BUF_COUNT = '0; BUF_EMPTY = 1'b1; DST_READY = 1'b0;
        repeat (3) cyc();
        check("rst_rd", BUF_RD, 0);
        check("rst_flush", BUF_FLUSH, 0);
        check("rst_playing", PLAYING, 0);
        check("rst_underrun", UNDERRUN, 0);
`ifdef SND_UNDERRUN_CNT_EN
        check("rst_under_cnt", UNDER_CNT, 0);
`endif

        // Prime: occupancy ramps across the 255/256 boundary.
        ARST = 1'b0; COMMAND = 2'b01; BUF_COUNT = 11'd100; BUF_EMPTY = 1'b0; DST_READY = 1'b1;
        cyc(); check("prime_cmd_reg", PLAYING, 0);
        cyc(); check("prime_wait", PLAYING, 0);
        BUF_COUNT = 11'd255;
        cyc(); check("prime_255", PLAYING, 0);
        BUF_COUNT = 11'd256;
        cyc(); check("prime_256", PLAYING, 1);

        // Pacing at RATE_DIV=3: a read every 4th cycle starting 5 cycles in.
        bad = 0; rdn = 0; undn = 0;
        for (int i = 1; i <= 403; i++) begin
            cyc();
            if (BUF_RD !== ((i >= 5) && ((i - 5) % 4 == 0))) bad++;
            rdn  += int'(BUF_RD);
            undn += int'(UNDERRUN);
        end
        check("pace_pattern_errs", bad, 0);
        check("pace_rd_count", rdn, 100);
        check("pace_underruns", undn, 0);

        // Backpressure: ready low for 6 cycles spanning one tick.
        DST_READY = 1'b0; rdn = 0; undn = 0; rd_pos = 0; und_pos = 0;
        for (int j = 1; j <= 8; j++) begin
            cyc();
            if (BUF_RD)   begin rdn++;  rd_pos  = j; end
            if (UNDERRUN) begin undn++; und_pos = j; end
            if (j == 6) DST_READY = 1'b1;
        end
        check("bp_underruns", undn, 1);
        check("bp_under_pos", und_pos, 5);
        check("bp_rd_count", rdn, 1);
        check("bp_rd_pos", rd_pos, 7);
`ifdef SND_UNDERRUN_CNT_EN
        check("bp_under_cnt", UNDER_CNT, 1);
`endif

        // Pause, then resume with occupancy far below the prime level.
        COMMAND = 2'b10; rdn = 0;
        cyc(); check("pause_lat", PLAYING, 1); rdn += int'(BUF_RD);
        BUF_COUNT = 11'd10;
        cyc(); check("pause_entered", PLAYING, 0); rdn += int'(BUF_RD);
        repeat (7) begin cyc(); rdn += int'(BUF_RD); end
        check("pause_no_rd", rdn, 0);
        check("pause_held", PLAYING, 0);
        COMMAND = 2'b01;
        cyc(); check("resume_lat", PLAYING, 0);
        cyc(); check("resume_no_prime", PLAYING, 1);
        rdn = 0; rd_pos = 0;
        for (int j = 1; j <= 5; j++) begin
            cyc();
            if (BUF_RD) begin rdn++; rd_pos = j; end
        end
        check("resume_rd_count", rdn, 1);
        check("resume_rd_pos", rd_pos, 5);

        // Flush from PLAY: exactly two BUF_FLUSH cycles, no reads, then IDLE.
        COMMAND = 2'b11; rdn = 0; fln = 0; fl_pos = 0;
        for (int j = 1; j <= 6; j++) begin
            cyc();
            if (j == 1) COMMAND = 2'b00;
            if (BUF_FLUSH) begin fln++; if (fl_pos == 0) fl_pos = j; end
            rdn += int'(BUF_RD);
        end
        check("flush_len", fln, 2);
        check("flush_pos", fl_pos, 2);
        check("flush_no_rd", rdn, 0);
        check("flush_idle", PLAYING, 0);
`ifdef SND_UNDERRUN_CNT_EN
        check("flush_clr_cnt", UNDER_CNT, 0);
`endif

        // Empty buffer at a tick drops back to PRIME with one underrun.
        BUF_COUNT = 11'd300; COMMAND = 2'b01;
        cyc();
        cyc(); check("replay_prime", PLAYING, 0);
        cyc(); check("replay_play", PLAYING, 1);
        BUF_EMPTY = 1'b1; BUF_COUNT = 11'd0; undn = 0;
        repeat (3) begin cyc(); undn += int'(UNDERRUN); end
        check("empty_pre_tick", undn, 0);
        cyc();
        check("empty_underrun", UNDERRUN, 1);
        check("empty_playing", PLAYING, 0);
        check("empty_rd", BUF_RD, 0);
`ifdef SND_UNDERRUN_CNT_EN
        check("empty_under_cnt", UNDER_CNT, 1);
`endif
        cyc();
        check("empty_pulse_end", UNDERRUN, 0);
        check("empty_in_prime", PLAYING, 0);

        // Reset mid-PLAY with a read about to be issued.
        BUF_COUNT = 11'd300; BUF_EMPTY = 1'b0;
        cyc(); check("reprime_play", PLAYING, 1);
        repeat (4) cyc();
        ARST = 1'b1;
        cyc();
        check("arst_play_rd", BUF_RD, 0);
        check("arst_play_playing", PLAYING, 0);
        check("arst_play_under", UNDERRUN, 0);
        check("arst_play_flush", BUF_FLUSH, 0);
        ARST = 1'b0;
        cyc();
        check("arst_no_residual_rd", BUF_RD, 0);
        check("arst_idle", PLAYING, 0);

        // Reset mid-FLUSH.
        COMMAND = 2'b11;
        cyc();
        COMMAND = 2'b00;
        cyc(); check("flush2_active", BUF_FLUSH, 1);
        ARST = 1'b1;
        cyc();
        check("arst_flush_abort", BUF_FLUSH, 0);
        check("arst_flush_playing", PLAYING, 0);
`ifdef SND_UNDERRUN_CNT_EN
        check("arst_cnt_clr", UNDER_CNT, 0);
`endif

        // RATE_DIV=0: a read every cycle with no underruns.
        ARST = 1'b0; RATE_DIV = 12'd0; COMMAND = 2'b01; BUF_COUNT = 11'd300;
        cyc();
        cyc();
        cyc(); check("div0_play", PLAYING, 1);
        rdn = 0; undn = 0;
        repeat (11) begin cyc(); rdn += int'(BUF_RD); undn += int'(UNDERRUN); end
        check("div0_rd_count", rdn, 10);
        check("div0_underruns", undn, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
